// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and defaults for the FIFO write arbiter.
//   arb_state_e   : arbiter FSM states (ARB_IDLE, ARB_LOCK)
//   NUM_REQ_DEF   : default requester count
//   BURST_LEN_DEF : default max beats per locked burst
package fifo_arb_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int BURST_LEN_DEF = 4;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority picker.
//   req_i : request vector
//   ptr_i : index with highest priority this cycle (search wraps N-1 -> 0)
//   gnt_o : one-hot grant (zero when no request)
//   idx_o : index of the granted bit
//   vld_o : some request was found
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  // Walk from the farthest offset down to offset 0 so the nearest
  // requester at or after ptr_i is the last one written and wins.
  always_comb begin
    int j;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
        vld_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one FIFO write port among NUM_REQ requesters.
// Round-robin in IDLE; with FIFO_ARB_BURST_EN defined a granted requester
// is locked for up to BURST_LEN consecutive beats.
//   clk, rst      : clock, asynchronous active-high reset
//   req/req_data  : per-requester request and data slice
//   gnt           : one-hot-or-zero grant (combinational)
//   fifo_full     : FIFO full flag; no grant while high
//   fifo_w_en     : FIFO write enable (= |gnt)
//   fifo_data_in  : granted requester's data, zero when idle
//   owner/locked  : locked requester index / LOCK state indicator
// Macro: FIFO_ARB_BURST_EN enables the LOCK/burst behaviour; undefined gives
// a pure round-robin arbiter and BURST_LEN is ignored.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = BURST_LEN_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          locked
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = 9;  // holds BURST_LEN up to 256

`ifdef FIFO_ARB_BURST_EN
  // A one-beat burst is just round-robin, so LOCK is never needed.
  localparam bit LOCK_EN = (BURST_LEN > 1);
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  arb_state_e    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_vld;
  logic               owner_req;

  function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  assign owner_req = req[owner_q];

  // Grant is combinational so the write lands this cycle; rst gates it so
  // nothing is written while reset is held.
  always_comb begin
    gnt = '0;
    if (!rst && !fifo_full) begin
      if (state_q == ARB_LOCK) begin
        if (owner_req) gnt[owner_q] = 1'b1;
      end else begin
        gnt = pick_gnt;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    if (!fifo_full) begin
      if (state_q == ARB_IDLE) begin
        if (pick_vld) begin
          if (LOCK_EN) begin
            state_d = ARB_LOCK;
            owner_d = pick_idx;
            cnt_d   = CW'(1);
          end else begin
            rr_ptr_d = inc_idx(pick_idx);
          end
        end
      end else if (!owner_req || (cnt_q + CW'(1) == CW'(BURST_LEN))) begin
        // Owner dropped (bubble cycle) or last beat of the burst accepted.
        state_d  = ARB_IDLE;
        rr_ptr_d = inc_idx(owner_q);
        owner_d  = '0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign fifo_w_en = |gnt;
  assign owner     = owner_q;
  assign locked    = (state_q == ARB_LOCK);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, BURST_LEN=4).
// Expectations follow FIFO_ARB_BURST_EN the same way the design does.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;
`ifdef FIFO_ARB_BURST_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic            fifo_full;
  logic            fifo_w_en;
  logic [DW-1:0]   fifo_data_in;
  logic [1:0]      owner;
  logic            locked;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_full    (fifo_full),
    .fifo_w_en    (fifo_w_en),
    .fifo_data_in (fifo_data_in),
    .owner        (owner),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] req;
    logic       full;
    logic [3:0] gnt;
    logic       locked;
    logic [1:0] owner;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] data;
    logic       locked;
    logic [1:0] owner;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  logic [7:0] fq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] slice_of(input logic [3:0] g);
    case (g)
      4'b0001: return 8'hA0;
      4'b0010: return 8'hB1;
      4'b0100: return 8'hC2;
      4'b1000: return 8'hD3;
      default: return 8'h00;
    endcase
  endfunction

  // One cycle: entered at posedge+1, drives inputs, checks at negedge.
  task automatic cyc(input string nm, input logic [3:0] r, input logic f,
                     input logic [3:0] eg, input logic el, input logic [1:0] eo);
    exp_t e;
    req       = r;
    fifo_full = f;
    sbq.push_back('{eg, slice_of(eg), el, eo});
    @(negedge clk);
    e = sbq.pop_front();
    chk({nm, " gnt"},    gnt,          e.gnt);
    chk({nm, " w_en"},   fifo_w_en,    |e.gnt);
    chk({nm, " data"},   fifo_data_in, e.data);
    chk({nm, " locked"}, locked,       e.locked);
    chk({nm, " owner"},  owner,        e.owner);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = '0;
    fifo_full = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req       = '1;
    fifo_full = 1'b0;
    req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

    // Reset state with requests pending.
    @(negedge clk);
    chk("rst gnt",    gnt,          0);
    chk("rst w_en",   fifo_w_en,    0);
    chk("rst data",   fifo_data_in, 0);
    chk("rst locked", locked,       0);
    chk("rst owner",  owner,        0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = '0;

    // Vector table, rr_ptr=0 at start.
    if (BE) begin
      tbl.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0});
      for (int k = 0; k < 17; k++)
        tbl.push_back('{4'b1111, 1'b0, 4'(1 << ((k / 4) % 4)), (k % 4) != 0,
                        ((k % 4) != 0) ? 2'((k / 4) % 4) : 2'd0});
    end else begin
      tbl.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0});
      tbl.push_back('{4'b1111, 1'b0, 4'b0001, 1'b0, 2'd0});
      tbl.push_back('{4'b1111, 1'b0, 4'b0010, 1'b0, 2'd0});
      tbl.push_back('{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0});
      tbl.push_back('{4'b1111, 1'b0, 4'b0100, 1'b0, 2'd0});
      tbl.push_back('{4'b1111, 1'b0, 4'b1000, 1'b0, 2'd0});
      tbl.push_back('{4'b1010, 1'b0, 4'b0010, 1'b0, 2'd0});
      tbl.push_back('{4'b1010, 1'b0, 4'b1000, 1'b0, 2'd0});
      tbl.push_back('{4'b1010, 1'b0, 4'b0010, 1'b0, 2'd0});
      tbl.push_back('{4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0});
      tbl.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0});
      tbl.push_back('{4'b1001, 1'b0, 4'b1000, 1'b0, 2'd0});
      tbl.push_back('{4'b1001, 1'b0, 4'b0001, 1'b0, 2'd0});
      tbl.push_back('{4'b0110, 1'b1, 4'b0000, 1'b0, 2'd0});
      tbl.push_back('{4'b0110, 1'b0, 4'b0010, 1'b0, 2'd0});
      tbl.push_back('{4'b0110, 1'b0, 4'b0100, 1'b0, 2'd0});
      tbl.push_back('{4'b0100, 1'b0, 4'b0100, 1'b0, 2'd0});
      tbl.push_back('{4'b1100, 1'b0, 4'b1000, 1'b0, 2'd0});
    end
    foreach (tbl[i])
      cyc($sformatf("row%0d", i), tbl[i].req, tbl[i].full, tbl[i].gnt,
          tbl[i].locked, tbl[i].owner);

    if (BE) begin
      // Full stall mid-burst: hold for 3 cycles, then exactly 2 beats remain.
      do_reset();
      cyc("stall b1", 4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0);
      cyc("stall b2", 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0);
      for (int i = 0; i < 3; i++)
        cyc($sformatf("stall f%0d", i), 4'b0001, 1'b1, 4'b0000, 1'b1, 2'd0);
      cyc("stall b3", 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0);
      cyc("stall b4", 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0);
      cyc("stall end", 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);

      // Owner 2 drops after one beat: bubble, then requester 3, then wrap to 0.
      do_reset();
      cyc("drop b1",  4'b1100, 1'b0, 4'b0100, 1'b0, 2'd0);
      cyc("drop bub", 4'b1000, 1'b0, 4'b0000, 1'b1, 2'd2);
      cyc("drop r3a", 4'b1000, 1'b0, 4'b1000, 1'b0, 2'd0);
      for (int i = 0; i < 3; i++)
        cyc($sformatf("drop r3%0d", i), 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3);
      cyc("drop wrap", 4'b1111, 1'b0, 4'b0001, 1'b0, 2'd0);
    end

    // Reset mid-burst (owner 1 after two beats when locking is enabled).
    do_reset();
    cyc("mid b1", 4'b0010, 1'b0, 4'b0010, 1'b0, 2'd0);
    cyc("mid b2", 4'b0010, 1'b0, 4'b0010, BE, BE ? 2'd1 : 2'd0);
    req = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    chk("mid rst gnt",    gnt,          0);
    chk("mid rst w_en",   fifo_w_en,    0);
    chk("mid rst data",   fifo_data_in, 0);
    chk("mid rst locked", locked,       0);
    chk("mid rst owner",  owner,        0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("mid after", 4'b1111, 1'b0, 4'b0001, 1'b0, 2'd0);

    // 8-deep FIFO, requesters 0..2 streaming, no reads.
    do_reset();
    for (int w = 0; w < 8; w++) begin
      int idx, k;
      idx = BE ? (w / 4) : (w % 3);
      k   = BE ? (w % 4) : (w / 3);
      fq.push_back({2'(idx), 6'(k)});
    end
    begin
      int cnt;
      int seq[3];
      cnt = 0;
      seq = '{0, 0, 0};
      for (int c = 0; c < 20; c++) begin
        req       = 4'b0111;
        fifo_full = (cnt >= 8);
        for (int i = 0; i < 3; i++) req_data[i*DW +: DW] = {2'(i), 6'(seq[i])};
        req_data[3*DW +: DW] = 8'h00;
        @(negedge clk);
        if (fifo_w_en) begin
          chk($sformatf("ff c%0d write while full", c), fifo_full, 0);
          if (fq.size() > 0) begin
            chk($sformatf("ff c%0d word", c), fifo_data_in, fq.pop_front());
          end else begin
            chk($sformatf("ff c%0d extra write", c), 1, 0);
          end
          cnt++;
          for (int i = 0; i < 3; i++) if (gnt[i]) seq[i]++;
        end
        @(posedge clk);
        #1;
      end
      chk("ff word count", cnt, 8);
      chk("ff leftover", fq.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
